noc_leaf_endpoint: RTL and testbench

- Client-side network interface that sits directly below one leaf port of the binary-tree NoC topology.
- Converts a processing element's valid/ready injection stream into credit-flow-controlled noc_if traffic toward the tree's leaf receiver.
- Buffers packets ejected from the tree's leaf transmitter in per-VC FIFOs, returns credits, and presents them to the PE through a round-robin valid/ready port.
- One instance per leaf; N instances surround the tree.

---
 rtl/noc_leaf_endpoint_if.sv | 16 +
 rtl/noc_leaf_endpoint.sv | 246 ++++++++++++++++++++++++
 tb/tb_noc_leaf_endpoint.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_leaf_endpoint_if.sv
// rtl/noc_leaf_endpoint_if.sv - noc_if link bundle between a leaf endpoint and the tree
//   vc_target     : one-hot VC strobe qualifying packet for one cycle
//   packet        : {dest, data}
//   vc_credit_gnt : per-VC credit return pulse, flowing opposite to packets
interface noc_if #(
    parameter int VC_W = 2,
    parameter int A_W  = 4,
    parameter int D_W  = 16
);
    logic [VC_W-1:0]    vc_target;
    logic [A_W+D_W-1:0] packet;
    logic [VC_W-1:0]    vc_credit_gnt;

    modport transmitter (output vc_target, output packet, input vc_credit_gnt);
    modport receiver    (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/noc_leaf_endpoint.sv
// rtl/noc_leaf_endpoint.sv - PE-side network interface below one leaf of the binary-tree NoC
//   Optional build macro NOC_EP_STATS_EN: enables stat_inj_cnt/stat_ej_cnt counters and the
//   ejected-destination assertion; otherwise both stat ports are tied to zero.
//   clk, rst (async active-low)
//   inj_valid/inj_ready/inj_vc/inj_dest/inj_data : PE injection stream
//   ej_valid/ej_ready/ej_vc/ej_data               : PE ejection stream (round-robin over VCs)
//   credit_err                                    : sticky protocol-error flag
//   net_tx / net_rx                               : noc_if links to the tree leaf rx / tx
//   stat_inj_cnt / stat_ej_cnt                    : packet counters
module noc_leaf_endpoint #(
    parameter int N             = 8,
    parameter int A_W           = $clog2(N) + 1,
    parameter int VC_W          = 2,
    parameter int D_W           = 16,
    parameter int VC_FIFO_DEPTH = 4,
    parameter int LEAF_ADDR     = 0,
    localparam int VCI_W        = (VC_W > 1) ? $clog2(VC_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inj_valid,
    output logic             inj_ready,
    input  logic [VCI_W-1:0] inj_vc,
    input  logic [A_W-1:0]   inj_dest,
    input  logic [D_W-1:0]   inj_data,
    output logic             ej_valid,
    input  logic             ej_ready,
    output logic [VCI_W-1:0] ej_vc,
    output logic [D_W-1:0]   ej_data,
    output logic             credit_err,
    noc_if.transmitter       net_tx,
    noc_if.receiver          net_rx,
    output logic [31:0]      stat_inj_cnt,
    output logic [31:0]      stat_ej_cnt
);
    localparam int P_W   = A_W + D_W;
    localparam int CR_W  = $clog2(VC_FIFO_DEPTH);
    localparam int SLOTS = VC_FIFO_DEPTH - 1;
    localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(VC_FIFO_DEPTH - 1);
    localparam logic [CR_W-1:0]  PTR_LAST = CR_W'(VC_FIFO_DEPTH - 2);
    localparam logic [CR_W-1:0]  CR_ONE   = CR_W'(1);
    localparam logic [VCI_W-1:0] VCI_ONE  = VCI_W'(1);
    localparam logic [VCI_W-1:0] VCI_LAST = VCI_W'(VC_W - 1);
    localparam logic [VC_W-1:0]  VC_ONE   = VC_W'(1);

    localparam logic [0:0] ST_INIT   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       state;
    logic [CR_W-1:0]  credit [VC_W];
    logic [CR_W-1:0]  sel_credit;
    logic             inj_fire;
    logic [VC_W-1:0]  inj_dec;
    logic [VC_W-1:0]  cred_ovf;
    logic [VC_W-1:0]  tx_tgt_q;
    logic [P_W-1:0]   tx_pkt_q;

    logic [P_W-1:0]   fifo_mem [VC_W][SLOTS];
    logic [CR_W-1:0]  wptr  [VC_W];
    logic [CR_W-1:0]  rptr  [VC_W];
    logic [CR_W-1:0]  count [VC_W];
    logic [VC_W-1:0]  rx_tgt;
    logic             rx_onehot;
    logic [VC_W-1:0]  wr_req;
    logic [VC_W-1:0]  wr_en;
    logic             wr_bad;

    logic             arb_found;
    logic [VCI_W-1:0] arb_win;
    logic [VCI_W-1:0] rr_ptr;
    logic             load_en;
    logic [VC_W-1:0]  pop_vec;
    logic [P_W-1:0]   head_pkt;
    logic [VC_W-1:0]  gnt_q;

    // INIT holds inj_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT;
        else      state <= ST_ACTIVE;
    end

    always_comb begin
        sel_credit = '0;
        for (int i = 0; i < VC_W; i++)
            if (inj_vc == VCI_W'(i)) sel_credit = credit[i];
    end

    assign inj_ready = (state == ST_ACTIVE) && (sel_credit != '0);
    assign inj_fire  = inj_valid && inj_ready;

    always_comb begin
        inj_dec  = '0;
        cred_ovf = '0;
        for (int i = 0; i < VC_W; i++) begin
            inj_dec[i]  = inj_fire && (inj_vc == VCI_W'(i));
            // A return on a full counter that is not cancelled by a same-cycle accept.
            cred_ovf[i] = net_tx.vc_credit_gnt[i] && (inj_fire ? (inj_vc != VCI_W'(i)) : 1'b1)
                          && (credit[i] == CR_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VC_W; i++) credit[i] <= CR_MAX;
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                if (net_tx.vc_credit_gnt[i] && !inj_dec[i] && credit[i] != CR_MAX)
                    credit[i] <= credit[i] + CR_ONE;
                else if (inj_dec[i] && !net_tx.vc_credit_gnt[i])
                    credit[i] <= credit[i] - CR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_tgt_q <= '0;
            tx_pkt_q <= '0;
        end else begin
            tx_tgt_q <= inj_dec;
            if (inj_fire) tx_pkt_q <= {inj_dest, inj_data};
        end
    end

    assign net_tx.vc_target = tx_tgt_q;
    assign net_tx.packet    = tx_pkt_q;

    // Fullness is judged before any same-cycle pop: write-when-full is always a drop.
    assign rx_tgt    = net_rx.vc_target;
    assign rx_onehot = (rx_tgt != '0) && ((rx_tgt & (rx_tgt - VC_ONE)) == '0);

    always_comb begin
        wr_req = '0;
        wr_en  = '0;
        for (int i = 0; i < VC_W; i++) begin
            wr_req[i] = rx_onehot && rx_tgt[i];
            wr_en[i]  = wr_req[i] && (count[i] != CR_MAX);
        end
    end

    assign wr_bad = ((rx_tgt != '0) && !rx_onehot) || ((wr_req & ~wr_en) != '0);

    always_ff @(posedge clk) begin
        for (int i = 0; i < VC_W; i++)
            if (wr_en[i]) fifo_mem[i][wptr[i]] <= net_rx.packet;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VC_W; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                if (wr_en[i])   wptr[i] <= (wptr[i] == PTR_LAST) ? '0 : wptr[i] + CR_ONE;
                if (pop_vec[i]) rptr[i] <= (rptr[i] == PTR_LAST) ? '0 : rptr[i] + CR_ONE;
                case ({wr_en[i], pop_vec[i]})
                    2'b10:   count[i] <= count[i] + CR_ONE;
                    2'b01:   count[i] <= count[i] - CR_ONE;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Round-robin: first non-empty VC at or above the pointer, then wrap to the ones below.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int i = 0; i < VC_W; i++) begin
            if (!arb_found && VCI_W'(i) >= rr_ptr && count[i] != '0) begin
                arb_found = 1'b1;
                arb_win   = VCI_W'(i);
            end
        end
        for (int i = 0; i < VC_W; i++) begin
            if (!arb_found && VCI_W'(i) < rr_ptr && count[i] != '0) begin
                arb_found = 1'b1;
                arb_win   = VCI_W'(i);
            end
        end
    end

    assign load_en  = !ej_valid || ej_ready;
    assign head_pkt = fifo_mem[arb_win][rptr[arb_win]];

    always_comb begin
        pop_vec = '0;
        for (int i = 0; i < VC_W; i++)
            pop_vec[i] = load_en && arb_found && (arb_win == VCI_W'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_valid <= 1'b0;
            ej_vc    <= '0;
            ej_data  <= '0;
            rr_ptr   <= '0;
            gnt_q    <= '0;
        end else begin
            gnt_q <= pop_vec;
            if (load_en) begin
                ej_valid <= arb_found;
                if (arb_found) begin
                    ej_vc   <= arb_win;
                    ej_data <= head_pkt[D_W-1:0];
                    rr_ptr  <= (arb_win == VCI_LAST) ? '0 : arb_win + VCI_ONE;
                end
            end
        end
    end

    assign net_rx.vc_credit_gnt = gnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      credit_err <= 1'b0;
        else if (wr_bad || cred_ovf != '0) credit_err <= 1'b1;
    end

`ifdef NOC_EP_STATS_EN
    logic [A_W-1:0] ej_dest_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_inj_cnt <= '0;
            stat_ej_cnt  <= '0;
            ej_dest_q    <= '0;
        end else begin
            if (inj_fire)             stat_inj_cnt <= stat_inj_cnt + 32'd1;
            if (ej_valid && ej_ready) stat_ej_cnt  <= stat_ej_cnt + 32'd1;
            if (load_en && arb_found) ej_dest_q    <= head_pkt[P_W-1:D_W];
        end
    end

    ej_dest_ok: assert property (@(posedge clk) disable iff (!rst)
        (ej_valid && ej_ready) |-> (ej_dest_q == A_W'(LEAF_ADDR)));
`else
    logic unused_stats;
    assign unused_stats = ^{head_pkt[P_W-1:D_W], LEAF_ADDR != 0};
    assign stat_inj_cnt = '0;
    assign stat_ej_cnt  = '0;
`endif

endmodule

// File: tb/tb_noc_leaf_endpoint.sv
// tb/tb_noc_leaf_endpoint.sv - self-checking bench for noc_leaf_endpoint
module tb_noc_leaf_endpoint;
    localparam int N     = 8;
    localparam int A_W   = 4;
    localparam int VC_W  = 2;
    localparam int D_W   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           inj_valid = 1'b0;
    logic           inj_ready;
    logic [0:0]     inj_vc    = 1'b0;
    logic [A_W-1:0] inj_dest  = '0;
    logic [D_W-1:0] inj_data  = '0;
    logic           ej_valid;
    logic           ej_ready  = 1'b0;
    logic [0:0]     ej_vc;
    logic [D_W-1:0] ej_data;
    logic           credit_err;
    logic [31:0]    stat_inj_cnt, stat_ej_cnt;

    noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) tx_if ();
    noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) rx_if ();

    noc_leaf_endpoint #(.N(N), .VC_W(VC_W), .D_W(D_W), .VC_FIFO_DEPTH(DEPTH), .LEAF_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_vc(inj_vc),
        .inj_dest(inj_dest), .inj_data(inj_data),
        .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_vc(ej_vc), .ej_data(ej_data),
        .credit_err(credit_err), .net_tx(tx_if), .net_rx(rx_if),
        .stat_inj_cnt(stat_inj_cnt), .stat_ej_cnt(stat_ej_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credit integers, packet queues per VC, round-robin over the queues.
    bit                  m_active;
    int                  m_credit [VC_W];
    logic [A_W+D_W-1:0]  m_q0 [$];
    logic [A_W+D_W-1:0]  m_q1 [$];
    bit                  m_out_valid;
    logic [0:0]          m_out_vc;
    logic [D_W-1:0]      m_out_data;
    int                  m_rr;
    logic [1:0]          m_tx_tgt;
    logic [A_W+D_W-1:0]  m_tx_pkt;
    logic [1:0]          m_gnt;
    bit                  m_err;
    int unsigned         m_inj_cnt, m_ej_cnt;

    function automatic int qsize(input int v);
        return (v == 0) ? m_q0.size() : m_q1.size();
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic fire;
        int   w;
        int   wr_v;
        logic [A_W+D_W-1:0] pkt;
        if (!rst) begin
            m_active = 0;
            m_credit[0] = DEPTH - 1;
            m_credit[1] = DEPTH - 1;
            m_q0.delete();
            m_q1.delete();
            m_out_valid = 0; m_out_vc = 0; m_out_data = 0; m_rr = 0;
            m_tx_tgt = 0; m_tx_pkt = 0; m_gnt = 0; m_err = 0;
            m_inj_cnt = 0; m_ej_cnt = 0;
        end else begin
            fire = inj_valid && m_active && (m_credit[inj_vc] > 0);
            for (int v = 0; v < VC_W; v++) begin
                m_credit[v] += int'(tx_if.vc_credit_gnt[v]) - ((fire && int'(inj_vc) == v) ? 1 : 0);
                if (m_credit[v] > DEPTH - 1) begin
                    m_credit[v] = DEPTH - 1;
                    m_err = 1;
                end
            end
            m_tx_tgt = fire ? (2'b01 << inj_vc) : 2'b00;
            if (fire) m_tx_pkt = {inj_dest, inj_data};
            if (fire) m_inj_cnt++;
            if (m_out_valid && ej_ready) m_ej_cnt++;

            wr_v = -1;
            if (rx_if.vc_target != 2'b00) begin
                if ($countones(rx_if.vc_target) != 1) m_err = 1;
                else if (qsize(int'(rx_if.vc_target[1])) >= DEPTH - 1) m_err = 1;
                else wr_v = int'(rx_if.vc_target[1]);
            end

            m_gnt = 2'b00;
            if (!m_out_valid || ej_ready) begin
                w = -1;
                for (int k = 0; k < VC_W; k++)
                    if (w < 0 && qsize((m_rr + k) % VC_W) > 0) w = (m_rr + k) % VC_W;
                if (w >= 0) begin
                    pkt = (w == 0) ? m_q0.pop_front() : m_q1.pop_front();
                    m_out_valid = 1;
                    m_out_vc    = w[0:0];
                    m_out_data  = pkt[D_W-1:0];
                    m_gnt[w]    = 1'b1;
                    m_rr        = (w + 1) % VC_W;
                end else begin
                    m_out_valid = 0;
                end
            end

            if (wr_v == 0) m_q0.push_back(rx_if.packet);
            if (wr_v == 1) m_q1.push_back(rx_if.packet);
            m_active = 1;
        end
    end

    always @(negedge clk) begin
        chk("inj_ready", inj_ready, m_active && (m_credit[inj_vc] > 0));
        chk("ej_valid", ej_valid, m_out_valid);
        if (m_out_valid) begin
            chk("ej_vc", ej_vc, m_out_vc);
            chk("ej_data", ej_data, m_out_data);
        end
        chk("tx_vc_target", tx_if.vc_target, m_tx_tgt);
        if (m_tx_tgt != 2'b00) chk("tx_packet", tx_if.packet, m_tx_pkt);
        chk("rx_credit_gnt", rx_if.vc_credit_gnt, m_gnt);
        chk("credit_err", credit_err, m_err);
`ifdef NOC_EP_STATS_EN
        chk("stat_inj", stat_inj_cnt, m_inj_cnt);
        chk("stat_ej", stat_ej_cnt, m_ej_cnt);
`else
        chk("stat_inj", stat_inj_cnt, 0);
        chk("stat_ej", stat_ej_cnt, 0);
`endif
    end

    int acc_cnt = 0;
    int tx0_cnt = 0;
    int g0_cnt  = 0;
    int g1_cnt  = 0;
    logic [16:0] ej_log [$];

    always @(negedge clk) begin
        if (inj_valid && inj_ready) acc_cnt++;
        if (tx_if.vc_target[0]) tx0_cnt++;
        if (rx_if.vc_credit_gnt[0]) g0_cnt++;
        if (rx_if.vc_credit_gnt[1]) g1_cnt++;
        if (ej_valid && ej_ready) ej_log.push_back({ej_vc, ej_data});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic deliver(input logic [1:0] tgt, input logic [19:0] pkt);
        rx_if.vc_target = tgt;
        rx_if.packet    = pkt;
        step(1);
        rx_if.vc_target = 2'b00;
    endtask

    task automatic chk_log(input string name, input int base, input logic [16:0] exp [5]);
        chk({name, "_count"}, ej_log.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < ej_log.size()) chk(name, ej_log[base + i], exp[i]);
    endtask

    initial begin
        int b_acc, b_tx0, b_g0, b_g1, b_log;
        logic [16:0] exp3 [5];
        logic [16:0] exp4 [5];
        exp3 = '{17'h03000, 17'h13100, 17'h03001, 17'h13101, 17'h13102};
        exp4 = '{17'h14000, 17'h04005, 17'h14001, 17'h14002, 17'h14003};
        tx_if.vc_credit_gnt = 2'b00;
        rx_if.vc_target     = 2'b00;
        rx_if.packet        = '0;

        // Reset values
        inj_valid = 1'b1; inj_vc = 1'b0; inj_dest = 4'h5;
        step(2);
        chk("rst_inj_ready", inj_ready, 0);
        chk("rst_ej_valid", ej_valid, 0);
        chk("rst_ej_data", ej_data, 0);
        chk("rst_tx_tgt", tx_if.vc_target, 0);
        chk("rst_tx_pkt", tx_if.packet, 0);
        chk("rst_gnt", rx_if.vc_credit_gnt, 0);
        chk("rst_err", credit_err, 0);

        // 1: INIT cycle, then exactly three accepts on vc0
        rst = 1'b1;
        #3;
        chk("init_ready", inj_ready, 0);
        step(1);
        b_acc = acc_cnt; b_tx0 = tx0_cnt;
        for (int i = 0; i < 8; i++) begin
            inj_data = 16'hA000 + 16'(i);
            step(1);
            if (i == 0) begin
                chk("first_tx_tgt", tx_if.vc_target, 2'b01);
                chk("first_tx_pkt", tx_if.packet, 20'h5A000);
            end
        end
        chk("sc1_accepts", acc_cnt - b_acc, 3);
        chk("sc1_tx_pulses", tx0_cnt - b_tx0, 3);
        chk("sc1_ready_low", inj_ready, 0);

        // 2: grant coincident with accept leaves the counter unchanged
        b_acc = acc_cnt;
        tx_if.vc_credit_gnt = 2'b01;
        step(2);
        tx_if.vc_credit_gnt = 2'b00;
        chk("sc2_same_cycle_hold", inj_ready, 1);
        step(1);
        chk("sc2_ready_low", inj_ready, 0);
        step(3);
        tx_if.vc_credit_gnt = 2'b01;
        step(1);
        tx_if.vc_credit_gnt = 2'b00;
        step(4);
        chk("sc2_accepts", acc_cnt - b_acc, 3);
        chk("sc2_no_err", credit_err, 0);
        inj_valid = 1'b0;

        // 3: buffered ejection with backpressure, then round-robin drain
        b_g0 = g0_cnt; b_g1 = g1_cnt; b_log = ej_log.size();
        deliver(2'b01, 20'h03000);
        deliver(2'b01, 20'h03001);
        deliver(2'b10, 20'h03100);
        deliver(2'b10, 20'h03101);
        deliver(2'b10, 20'h03102);
        step(3);
        chk("sc3_hold_valid", ej_valid, 1);
        chk("sc3_hold_data", ej_data, 16'h3000);
        step(2);
        chk("sc3_hold_data2", ej_data, 16'h3000);
        ej_ready = 1'b1;
        step(6);
        ej_ready = 1'b0;
        chk_log("sc3_order", b_log, exp3);
        chk("sc3_gnt_vc0", g0_cnt - b_g0, 2);
        chk("sc3_gnt_vc1", g1_cnt - b_g1, 3);

        // 4: arrival to a full vc1 FIFO is dropped
        b_log = ej_log.size();
        deliver(2'b10, 20'h04000);
        step(2);
        deliver(2'b10, 20'h04001);
        deliver(2'b10, 20'h04002);
        deliver(2'b10, 20'h04003);
        chk("sc4_err_before", credit_err, 0);
        deliver(2'b10, 20'h04004);
        chk("sc4_err_set", credit_err, 1);
        deliver(2'b01, 20'h04005);
        step(2);
        ej_ready = 1'b1;
        step(7);
        ej_ready = 1'b0;
        chk_log("sc4_order", b_log, exp4);
        chk("sc4_err_sticky", credit_err, 1);

        // 5: reset mid-traffic, then a non-one-hot target, then credit saturation
        inj_valid = 1'b1; inj_vc = 1'b1;
        rx_if.vc_target = 2'b01; rx_if.packet = 20'h05000;
        step(1);
        rst = 1'b0;
        #1;
        chk("mid_rst_inj_ready", inj_ready, 0);
        chk("mid_rst_ej_valid", ej_valid, 0);
        chk("mid_rst_ej_data", ej_data, 0);
        chk("mid_rst_tx_tgt", tx_if.vc_target, 0);
        chk("mid_rst_tx_pkt", tx_if.packet, 0);
        chk("mid_rst_err", credit_err, 0);
        rx_if.vc_target = 2'b00;
        step(2);
        rst = 1'b1;
        step(1);
        b_acc = acc_cnt;
        step(6);
        chk("sc5_credits_restored", acc_cnt - b_acc, 3);
        chk("sc5_fifo_flushed", ej_valid, 0);
        inj_valid = 1'b0;
        deliver(2'b11, 20'h06000);
        chk("sc5_bad_tgt_err", credit_err, 1);
        step(3);
        chk("sc5_bad_tgt_nowrite", ej_valid, 0);

        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(2);
        tx_if.vc_credit_gnt = 2'b10;
        step(1);
        tx_if.vc_credit_gnt = 2'b00;
        chk("sc5_sat_err", credit_err, 1);
        inj_valid = 1'b1; inj_vc = 1'b1;
        b_acc = acc_cnt;
        step(6);
        inj_valid = 1'b0;
        chk("sc5_sat_accepts", acc_cnt - b_acc, 3);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
